sound_detect: RTL and testbench
===============================

SOUND_DETECT -- requirements
Module: sound_detect

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the period counter.
REQ-002 SHALL have parameter PERIOD_MIN, default 4: shortest valid tone period, in clk cycles.
REQ-003 SHALL have parameter PERIOD_MAX, default 8: longest valid tone period, in clk cycles.
REQ-004 SHALL have parameter HITS, default 3: consecutive valid periods required to lock.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port sound_in, input, 1 bit: asynchronous square-wave tone from the buzzer/microphone line.
REQ-008 SHALL have port clr_cnt, input, 1 bit: synchronous clear of evt_count.
REQ-009 SHALL have port tone_on, output, 1 bit: level, high while a valid tone is locked.
REQ-010 SHALL have port shock_evt, output, 1 bit: one-cycle pulse on each tone_on rise.
REQ-011 SHALL have port evt_count, output, 8 bits: number of tone events detected.

Function
REQ-012 SHALL pass sound_in through a 2-flop synchronizer, then a third flop for rise detection; edge = sync2 & ~sync3.
REQ-013 SHALL assert the internal edge 3 clk rising edges after sound_in goes high, relative to the first clk edge that samples the high level.
REQ-014 SHALL load per_cnt with 1 on an edge cycle.
REQ-015 SHALL otherwise increment per_cnt by 1, saturating at PERIOD_MAX+1.
REQ-016 SHALL use the per_cnt value present on an edge cycle, before update, as measured period P.
REQ-017 SHALL treat P as valid iff PERIOD_MIN <= P <= PERIOD_MAX.
REQ-018 SHALL implement FSM states IDLE, MEASURE, LOCKED, with hit counter hit.
REQ-019 SHALL, in IDLE, go to MEASURE on an edge and clear hit; per_cnt from before that edge is ignored.
REQ-020 SHALL, in MEASURE, increment hit on a valid-P edge.
REQ-021 SHALL, in MEASURE, go to LOCKED when hit would reach HITS.
REQ-022 SHALL, in MEASURE, clear hit and stay in MEASURE on an invalid-P edge; that edge starts a new period.
REQ-023 SHALL, in MEASURE, go to IDLE when per_cnt saturates.
REQ-024 SHALL, in LOCKED, stay in LOCKED on a valid-P edge.
REQ-025 SHALL, in LOCKED, go to IDLE on an invalid-P edge or per_cnt saturation.
REQ-026 SHALL make tone_on a registered output, high exactly while the state is LOCKED.
REQ-027 SHALL assert tone_on on the clk edge after the qualifying edge cycle.
REQ-028 SHALL pulse shock_evt for exactly one cycle, coincident with the first cycle tone_on is high.
REQ-029 SHALL increment evt_count on each shock_evt, wrapping 255 -> 0.
REQ-030 SHALL set evt_count to 0 on a clr_cnt cycle without shock_evt.
REQ-031 SHALL set evt_count to 1 when clr_cnt coincides with shock_evt.
REQ-032 SHALL not produce a new shock_evt when an edge arrives on the same cycle per_cnt saturates in LOCKED; the state goes to IDLE.

Reset
REQ-033 SHALL, while rst=0, force state to IDLE, hit to 0, per_cnt to 0 and all synchronizer flops to 0.
REQ-034 SHALL, while rst=0, force tone_on, shock_evt and evt_count to 0, independent of clk.
REQ-035 SHALL drop tone_on immediately on a reset during LOCKED.
REQ-036 SHALL, after rst rises, require a full fresh lock sequence before tone_on can assert.

Structure
REQ-037 SHALL place the state encoding (IDLE=0, MEASURE=1, LOCKED=2) and default PERIOD_MIN, PERIOD_MAX and HITS values in shared package sound_pkg, used by shock_sound benches too.
REQ-038 SHALL put the synchronizer and rise detect in sub-module sync_edge (clk, rst, din, edge).

Verification
REQ-039 SHALL cover: rst=0 with sound_in toggling -> tone_on=0, shock_evt=0, evt_count=0 throughout.
REQ-040 SHALL cover: period-6 square wave, 5 rises -> tone_on high 1 cycle after 4th edge, one shock_evt, evt_count=1.
REQ-041 SHALL cover: period-3 square wave, 10 rises -> tone_on never high, evt_count=0.
REQ-042 SHALL cover: lock at period 6, then sound_in held low -> tone_on falls when per_cnt reaches 9, i.e. 9 cycles after last edge; evt_count stays 1.
REQ-043 SHALL cover: lock, drop tone, relock, with clr_cnt=1 on the 2nd shock_evt cycle -> evt_count=1.
REQ-044 SHALL cover: rst=0 pulse for 2 cycles while LOCKED -> tone_on and evt_count 0 immediately; relock needs 4 more edges.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared definitions for the tone detector and its benches.
//   state_e      : detector FSM encoding (idle / measuring / locked)
//   Def*         : default tone-window and lock-count parameters
package sound_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMeasure = 2'd1,
    StLocked  = 2'd2
  } state_e;

  // Default valid tone window, in clk cycles per rising edge of the tone.
  localparam int unsigned DefPeriodMin = 4;
  localparam int unsigned DefPeriodMax = 8;

  // Default number of consecutive in-window periods needed to declare a tone.
  localparam int unsigned DefHits = 3;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous line, followed by a third flop used
// to detect a rising edge of the synchronized level.
//   clk  : sampling clock
//   rst  : asynchronous active-low reset, clears all three flops
//   din  : asynchronous input level
//   rise : one-cycle pulse, high while the synchronized level has just gone 0 -> 1
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1_q, sync2_q, sync3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // sync2_q is the first metastability-safe copy; sync3_q is its one-cycle-old value.
  assign rise = sync2_q & ~sync3_q;

endmodule

// File: rtl/sound_detect.sv
// Tone detector for a buzzer/microphone square wave.
// Measures the clk-cycle distance between successive rising edges of sound_in.
// After HITS consecutive distances inside [PERIOD_MIN, PERIOD_MAX] the tone is
// declared locked; it stays locked while periods stay in the window and drops
// on an out-of-window period or on silence longer than PERIOD_MAX cycles.
//   clk       : single clock, all state changes on its rising edge
//   rst       : asynchronous active-low reset
//   sound_in  : asynchronous tone input
//   clr_cnt   : synchronous clear of evt_count
//   tone_on   : registered level, high while locked
//   shock_evt : one-cycle pulse on the first locked cycle
//   evt_count : number of tone events seen, wraps at 255
module sound_detect
  import sound_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PERIOD_MIN = DefPeriodMin,
  parameter int unsigned PERIOD_MAX = DefPeriodMax,
  parameter int unsigned HITS       = DefHits
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sound_in,
  input  logic       clr_cnt,
  output logic       tone_on,
  output logic       shock_evt,
  output logic [7:0] evt_count
);

  localparam int unsigned HitW = (HITS < 2) ? 1 : $clog2(HITS + 1);

  localparam logic [CNT_W-1:0] PerOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] PerMin = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] PerMax = CNT_W'(PERIOD_MAX);
  // Saturation value doubles as the "silence" marker: one past the longest valid period.
  localparam logic [CNT_W-1:0] PerSat = CNT_W'(PERIOD_MAX + 1);

  // Hit count at which one more valid period completes the lock.
  localparam logic [HitW-1:0] HitLast = HitW'(HITS - 1);

  // ---------------------------------------------------------------------------
  // Input synchronization and edge detection
  // ---------------------------------------------------------------------------
  logic rise;

  sync_edge u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (sound_in),
    .rise (rise)
  );

  // ---------------------------------------------------------------------------
  // Period counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic             per_sat;
  logic             per_valid;

  // per_cnt_q on an edge cycle is the measured period (distance from the previous edge).
  assign per_sat   = (per_cnt_q == PerSat);
  assign per_valid = (per_cnt_q >= PerMin) && (per_cnt_q <= PerMax);

  always_comb begin
    per_cnt_d = per_cnt_q;
    if (rise) begin
      per_cnt_d = PerOne;
    end else if (!per_sat) begin
      per_cnt_d = per_cnt_q + PerOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Detector FSM: state register
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [HitW-1:0] hit_q, hit_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Detector FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    unique case (state_q)
      StIdle: begin
        // The counter value before the first edge is meaningless; just start measuring.
        if (rise) begin
          state_d = StMeasure;
          hit_d   = '0;
        end
      end
      StMeasure: begin
        // Silence wins over a coincident edge: a saturated count is never a valid period.
        if (per_sat) begin
          state_d = StIdle;
          hit_d   = '0;
        end else if (rise) begin
          if (!per_valid) begin
            hit_d = '0;
          end else if (hit_q == HitLast) begin
            state_d = StLocked;
            hit_d   = '0;
          end else begin
            hit_d = hit_q + HitW'(1);
          end
        end
      end
      StLocked: begin
        if (per_sat || (rise && !per_valid)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        hit_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Detector FSM: outputs
  // ---------------------------------------------------------------------------
  logic       tone_q, tone_d;
  logic       shock_q, shock_d;
  logic [7:0] evt_count_q, evt_count_d;

  always_comb begin
    // Outputs are registered from the next state so they line up with the state itself.
    tone_d  = (state_d == StLocked);
    shock_d = (state_d == StLocked) && (state_q != StLocked);

    // The event being reported this cycle survives a simultaneous clear.
    evt_count_d = evt_count_q;
    if (clr_cnt) begin
      evt_count_d = shock_q ? 8'd1 : 8'd0;
    end else if (shock_q) begin
      evt_count_d = evt_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tone_q      <= 1'b0;
      shock_q     <= 1'b0;
      evt_count_q <= 8'd0;
    end else begin
      tone_q      <= tone_d;
      shock_q     <= shock_d;
      evt_count_q <= evt_count_d;
    end
  end

  assign tone_on   = tone_q;
  assign shock_evt = shock_q;
  assign evt_count = evt_count_q;

endmodule

// File: tb/tb_sound_detect.sv
// Randomized bench for sound_detect against a timestamp-based reference model.
module tb_sound_detect;

  localparam int PMin  = 4;
  localparam int PMax  = 8;
  localparam int NHits = 3;

  logic       clk;
  logic       rst;
  logic       sound_in;
  logic       clr_cnt;
  logic       tone_on;
  logic       shock_evt;
  logic [7:0] evt_count;

  sound_detect #(
    .CNT_W      (16),
    .PERIOD_MIN (PMin),
    .PERIOD_MAX (PMax),
    .HITS       (NHits)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sound_in  (sound_in),
    .clr_cnt   (clr_cnt),
    .tone_on   (tone_on),
    .shock_evt (shock_evt),
    .evt_count (evt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: samples of sound_in per clk edge, time of last tone edge,
  // detector mode (0 idle, 1 measuring, 2 locked) and counted valid periods.
  bit     smp[$];
  longint cyc = 0;
  longint m_last = 0;
  int     m_mode = 0;
  int     m_hits = 0;
  bit     m_tone = 0;
  bit     m_shock = 0;
  int     m_cnt = 0;

  bit clr_on_shock = 0;
  int n_shock_seen = 0;
  bit tone_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    smp = '{0, 0, 0};
    m_last  = cyc;
    m_mode  = 0;
    m_hits  = 0;
    m_tone  = 0;
    m_shock = 0;
    m_cnt   = 0;
  endtask

  // One clk rising edge with inputs s and c present.
  task automatic model_step(input bit s, input bit c);
    bit     e;
    bit     sat;
    bit     valid;
    longint p;
    int     prev;
    cyc++;
    if (!rst) begin
      model_reset();
    end else begin
      // A rise first sampled at edge k is acted on at edge k+2.
      e = smp[$-1] && !smp[$-2];
      smp.push_back(s);
      while (smp.size() > 3) void'(smp.pop_front());

      p = cyc - m_last;
      if (p > PMax + 1) p = PMax + 1;
      sat   = (p == PMax + 1);
      valid = (p >= PMin) && (p <= PMax);
      prev  = m_mode;

      if (m_mode == 0) begin
        if (e) begin m_mode = 1; m_hits = 0; end
      end else if (m_mode == 1) begin
        if (sat) begin
          m_mode = 0; m_hits = 0;
        end else if (e) begin
          if (!valid) m_hits = 0;
          else if (m_hits + 1 == NHits) begin m_mode = 2; m_hits = 0; end
          else m_hits++;
        end
      end else begin
        if (sat || (e && !valid)) m_mode = 0;
      end
      if (e) m_last = cyc;

      if (c) m_cnt = m_shock ? 1 : 0;
      else if (m_shock) m_cnt = (m_cnt + 1) % 256;
      m_shock = (m_mode == 2) && (prev != 2);
      m_tone  = (m_mode == 2);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit s, input bit c);
    bit ce;
    ce = c | (clr_on_shock & shock_evt);
    sound_in = s;
    clr_cnt  = ce;
    @(posedge clk);
    model_step(s, ce);
    #1;
    if (shock_evt) n_shock_seen++;
    if (tone_on) tone_seen = 1;
    check_eq("tone_on", tone_on, m_tone);
    check_eq("shock_evt", shock_evt, m_shock);
    check_eq("evt_count", evt_count, m_cnt);
    @(negedge clk);
  endtask

  task automatic wave(input int per, input int rises, input int tail, input int clr_pct);
    for (int r = 0; r < rises; r++) begin
      for (int i = 0; i < per; i++) begin
        step(i < (per + 1) / 2, int'($urandom_range(0, 99)) < clr_pct);
      end
    end
    for (int i = 0; i < tail; i++) step(1'b0, int'($urandom_range(0, 99)) < clr_pct);
  endtask

  // Called at a negedge; reset takes effect immediately, sound_in toggles meanwhile.
  task automatic do_reset(input int cycles);
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_tone_on", tone_on, 0);
    check_eq("rst_shock_evt", shock_evt, 0);
    check_eq("rst_evt_count", evt_count, 0);
    for (int i = 0; i < cycles; i++) step(1'($urandom_range(0, 1)), 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    sound_in = 1'b0;
    clr_cnt  = 1'b0;
    @(negedge clk);

    // Long reset with a toggling input.
    do_reset(12);

    // Period 6, five rises: lock after the fourth edge, a single event.
    n_shock_seen = 0;
    wave(6, 5, 0, 0);
    check_eq("p6_shocks", n_shock_seen, 1);
    check_eq("p6_tone", tone_on, 1);
    check_eq("p6_count", evt_count, 1);

    // Silence after lock: tone drops, count holds.
    wave(6, 0, 20, 0);
    check_eq("silence_tone", tone_on, 0);
    check_eq("silence_count", evt_count, 1);

    // Period 3 is too short to ever lock.
    do_reset(2);
    tone_seen = 0;
    wave(3, 10, 12, 0);
    check_eq("p3_tone_seen", tone_seen, 0);
    check_eq("p3_count", evt_count, 0);

    // Lock, drop, relock with clear on the second event.
    do_reset(2);
    wave(6, 5, 12, 0);
    clr_on_shock = 1;
    n_shock_seen = 0;
    wave(6, 5, 0, 0);
    clr_on_shock = 0;
    check_eq("clr_shocks", n_shock_seen, 1);
    check_eq("clr_count", evt_count, 1);

    // Reset while locked, then a fresh lock needs four edges.
    wave(6, 2, 0, 0);
    do_reset(2);
    tone_seen = 0;
    wave(6, 3, 0, 0);
    check_eq("relock_3_edges", tone_seen, 0);
    wave(6, 2, 0, 0);
    check_eq("relock_4_edges", tone_on, 1);
    check_eq("relock_count", evt_count, 1);

    // 256 events wrap the counter back to zero.
    do_reset(2);
    for (int k = 0; k < 256; k++) wave(5, 4, 12, 0);
    check_eq("wrap_count", evt_count, 0);

    // Random tones, gaps, clears and resets.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) do_reset(int'($urandom_range(1, 3)));
      wave(int'($urandom_range(2, 12)), int'($urandom_range(1, 8)),
           int'($urandom_range(0, 14)), 5);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
